// File: rtl/jtag_data_register_if.sv
// DR-path signal bundle between the TAP controller (master) and one test data register (slave).
// count is exposed read-only so the shift-length state can be observed by checkers.
interface jtag_data_register_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH + 2);

  logic             testLogicReset;
  logic             select;
  logic             captureDR;
  logic             shiftDR;
  logic             updateDR;
  logic             tdi;
  logic [WIDTH-1:0] captureData;
  logic             tdo;
  logic [WIDTH-1:0] updateData;
  logic             updateStrobe;
  logic             lengthError;
  logic [CW-1:0]    count;

  modport master (
    output testLogicReset, select, captureDR, shiftDR, updateDR, tdi, captureData,
    input  tdo, updateData, updateStrobe, lengthError, count
  );

  modport slave (
    input  testLogicReset, select, captureDR, shiftDR, updateDR, tdi, captureData,
    output tdo, updateData, updateStrobe, lengthError, count
  );
endinterface

// File: rtl/jtag_data_register.sv
// 1149.1 test data register: capture/shift/update stages with a shift-length check
// that refuses the update latch when the scan since the last capture was not exactly WIDTH bits.
module jtag_data_register #(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter bit               STRICT_LENGTH = 1'b1
) (
  input logic                tck,
  input logic                trst_n,
  jtag_data_register_if.slave dr
);
  localparam int CW = $clog2(WIDTH + 2);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] update_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_inc;
  logic             strobe_q;
  logic             len_err_q;
  logic             commit;

  generate
    if (WIDTH == 1) begin : g_one
      assign shift_next = dr.tdi;
    end else begin : g_wide
      assign shift_next = {dr.tdi, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  // Saturate at WIDTH+1 so an overlong scan can never wrap back to WIDTH.
  assign count_inc = (count_q == CW'(WIDTH + 1)) ? count_q : count_q + 1'b1;
  assign commit    = !STRICT_LENGTH || (count_q == CW'(WIDTH));

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      shift_reg <= RESET_VALUE;
      update_q  <= RESET_VALUE;
      count_q   <= '0;
      strobe_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (dr.testLogicReset) begin
        shift_reg <= RESET_VALUE;
        update_q  <= RESET_VALUE;
        count_q   <= '0;
        len_err_q <= 1'b0;
      end else if (dr.select && dr.captureDR) begin
        shift_reg <= dr.captureData;
        count_q   <= '0;
        len_err_q <= 1'b0;
      end else if (dr.select && dr.shiftDR) begin
        shift_reg <= shift_next;
        count_q   <= count_inc;
      end else if (dr.select && dr.updateDR) begin
        count_q <= '0;
        if (commit) begin
          update_q  <= shift_reg;
          strobe_q  <= 1'b1;
          len_err_q <= 1'b0;
        end else begin
          len_err_q <= 1'b1;
        end
      end
    end
  end

  assign dr.tdo          = shift_reg[0];
  assign dr.updateData   = update_q;
  assign dr.updateStrobe = strobe_q;
  assign dr.lengthError  = len_err_q;
  assign dr.count        = count_q;
endmodule

// File: tb/tb_jtag_data_register.sv
// Bench for jtag_data_register: strict and non-strict 8-bit instances driven in lockstep, plus a
// 1-bit bypass-style instance; committed updates are checked against an expected queue per instance.
module tb_jtag_data_register;
  logic tck = 1'b0;
  logic trst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [0:0] qc[$];
  logic       prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

  jtag_data_register_if #(.WIDTH(8)) ifa ();
  jtag_data_register_if #(.WIDTH(8)) ifb ();
  jtag_data_register_if #(.WIDTH(1)) ifc ();

  jtag_data_register #(.WIDTH(8), .RESET_VALUE(8'hA5), .STRICT_LENGTH(1'b1))
    dut_a (.tck(tck), .trst_n(trst_n), .dr(ifa));
  jtag_data_register #(.WIDTH(8), .RESET_VALUE(8'hA5), .STRICT_LENGTH(1'b0))
    dut_b (.tck(tck), .trst_n(trst_n), .dr(ifb));
  jtag_data_register #(.WIDTH(1), .RESET_VALUE(1'b0), .STRICT_LENGTH(1'b0))
    dut_c (.tck(tck), .trst_n(trst_n), .dr(ifc));

  // clock / reset
  always #5 tck = ~tck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge tck);
    #1;
  endtask

  task automatic drive(input logic sel, cap, sh, upd, tlr, td);
    ifa.select = sel; ifa.captureDR = cap; ifa.shiftDR = sh; ifa.updateDR = upd;
    ifa.testLogicReset = tlr; ifa.tdi = td;
    ifb.select = sel; ifb.captureDR = cap; ifb.shiftDR = sh; ifb.updateDR = upd;
    ifb.testLogicReset = tlr; ifb.tdi = td;
    cyc();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_cap(input logic [7:0] v);
    ifa.captureData = v;
    ifb.captureData = v;
  endtask

  task automatic drive_c(input logic cap, sh, upd, td);
    ifc.select = 1'b1; ifc.captureDR = cap; ifc.shiftDR = sh; ifc.updateDR = upd; ifc.tdi = td;
    cyc();
  endtask

  // scoreboard monitors: every strobe must match the next queued commit, never two cycles running
  always @(negedge tck) begin
    if (trst_n && ifa.updateStrobe) begin
      n_tests++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL mon_a: unexpected strobe, updateData=%h", ifa.updateData);
      end else begin
        logic [7:0] e;
        e = qa.pop_front();
        if (ifa.updateData !== e) begin
          n_fail++;
          $display("[TB] FAIL mon_a: updateData=%h expected %h", ifa.updateData, e);
        end
      end
      chk("mon_a_strobe_twice", {31'd0, prev_a}, 32'd0);
    end
    prev_a = ifa.updateStrobe;
  end

  always @(negedge tck) begin
    if (trst_n && ifb.updateStrobe) begin
      n_tests++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL mon_b: unexpected strobe, updateData=%h", ifb.updateData);
      end else begin
        logic [7:0] e;
        e = qb.pop_front();
        if (ifb.updateData !== e) begin
          n_fail++;
          $display("[TB] FAIL mon_b: updateData=%h expected %h", ifb.updateData, e);
        end
      end
      chk("mon_b_strobe_twice", {31'd0, prev_b}, 32'd0);
    end
    prev_b = ifb.updateStrobe;
  end

  always @(negedge tck) begin
    if (trst_n && ifc.updateStrobe) begin
      n_tests++;
      if (qc.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL mon_c: unexpected strobe, updateData=%h", ifc.updateData);
      end else begin
        logic [0:0] e;
        e = qc.pop_front();
        if (ifc.updateData !== e) begin
          n_fail++;
          $display("[TB] FAIL mon_c: updateData=%h expected %h", ifc.updateData, e);
        end
      end
      chk("mon_c_strobe_twice", {31'd0, prev_c}, 32'd0);
    end
    prev_c = ifc.updateStrobe;
  end

  initial begin
    logic [7:0]  tdo_exp;
    logic [7:0]  tdi_vec;
    logic [19:0] pat;
    logic [3:0]  byp;

    trst_n = 1'b0;
    set_cap(8'h00);
    ifa.select = 1'b0; ifa.captureDR = 1'b0; ifa.shiftDR = 1'b0; ifa.updateDR = 1'b0;
    ifa.testLogicReset = 1'b0; ifa.tdi = 1'b0;
    ifb.select = 1'b0; ifb.captureDR = 1'b0; ifb.shiftDR = 1'b0; ifb.updateDR = 1'b0;
    ifb.testLogicReset = 1'b0; ifb.tdi = 1'b0;
    ifc.select = 1'b0; ifc.captureDR = 1'b0; ifc.shiftDR = 1'b0; ifc.updateDR = 1'b0;
    ifc.testLogicReset = 1'b0; ifc.tdi = 1'b0; ifc.captureData = 1'b0;

    #12;
    chk("rst_a_updateData", ifa.updateData, 8'hA5);
    chk("rst_a_tdo", ifa.tdo, 1);
    chk("rst_a_lengthError", ifa.lengthError, 0);
    chk("rst_a_strobe", ifa.updateStrobe, 0);
    chk("rst_a_count", ifa.count, 0);
    chk("rst_c_tdo", ifc.tdo, 0);
    trst_n = 1'b1;
    cyc();

    // update without any capture: strict refuses, non-strict commits the reset value
    qb.push_back(8'hA5);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("nocap_a_lengthError", ifa.lengthError, 1);
    chk("nocap_a_strobe", ifa.updateStrobe, 0);
    chk("nocap_a_updateData", ifa.updateData, 8'hA5);
    idle();

    // exact-length scan
    set_cap(8'h3C);
    tdo_exp = 8'h3C;
    tdi_vec = 8'h4D;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("exact_cap_lengthError", ifa.lengthError, 0);
    chk("exact_cap_count", ifa.count, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("exact_tdo_%0d", k), ifa.tdo, tdo_exp[k]);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, tdi_vec[k]);
    end
    chk("exact_count", ifa.count, 8);
    qa.push_back(8'h4D);
    qb.push_back(8'h4D);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("exact_strobe_hi", ifa.updateStrobe, 1);
    chk("exact_updateData", ifa.updateData, 8'h4D);
    chk("exact_lengthError", ifa.lengthError, 0);
    chk("exact_count_after", ifa.count, 0);
    idle();
    chk("exact_strobe_lo", ifa.updateStrobe, 0);

    // trst_n pulse mid-shift, no clock edge in between
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 trst_n = 1'b0;
    #1;
    chk("trst_a_updateData", ifa.updateData, 8'hA5);
    chk("trst_a_tdo", ifa.tdo, 1);
    chk("trst_a_lengthError", ifa.lengthError, 0);
    chk("trst_a_strobe", ifa.updateStrobe, 0);
    chk("trst_a_count", ifa.count, 0);
    chk("trst_b_updateData", ifb.updateData, 8'hA5);
    #1 trst_n = 1'b1;
    idle();

    // short scan: 7 shifts of 1 from 8'h3C
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    qb.push_back(8'hFE);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("short_a_updateData", ifa.updateData, 8'hA5);
    chk("short_a_lengthError", ifa.lengthError, 1);
    chk("short_a_strobe", ifa.updateStrobe, 0);
    chk("short_b_lengthError", ifb.lengthError, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("short_recap_lengthError", ifa.lengthError, 0);

    // long scan: 20 shifts, last 8 tdi bits are 8'h96
    pat = 20'h960F3;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pat[k]);
      if (k == 8) chk("long_count_9", ifa.count, 9);
    end
    chk("long_count_sat", ifa.count, 9);
    qb.push_back(8'h96);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("long_a_lengthError", ifa.lengthError, 1);
    chk("long_a_updateData", ifa.updateData, 8'hA5);
    chk("long_a_count", ifa.count, 0);
    chk("long_b_updateData", ifb.updateData, 8'h96);
    idle();

    // select low: every strobe ignored
    set_cap(8'hFF);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("gate_a_tdo", ifa.tdo, 0);
    chk("gate_a_updateData", ifa.updateData, 8'hA5);
    chk("gate_a_lengthError", ifa.lengthError, 1);
    chk("gate_a_count", ifa.count, 0);
    chk("gate_b_updateData", ifb.updateData, 8'h96);

    // capture and shift together: capture only
    set_cap(8'h82);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("capsh_tdo", ifa.tdo, 0);
    chk("capsh_count", ifa.count, 0);
    chk("capsh_lengthError", ifa.lengthError, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("capsh_shift_tdo", ifa.tdo, 1);
    chk("capsh_shift_count", ifa.count, 1);

    // testLogicReset beats updateDR
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("tlr_a_updateData", ifa.updateData, 8'hA5);
    chk("tlr_a_tdo", ifa.tdo, 1);
    chk("tlr_a_count", ifa.count, 0);
    chk("tlr_a_strobe", ifa.updateStrobe, 0);
    chk("tlr_b_updateData", ifb.updateData, 8'hA5);
    chk("tlr_b_strobe", ifb.updateStrobe, 0);
    idle();

    // bypass-style 1-bit register
    byp = 4'b1101;
    drive_c(1'b1, 1'b0, 1'b0, 1'b1);
    chk("byp_cap_tdo", ifc.tdo, 0);
    for (int k = 0; k < 4; k++) begin
      drive_c(1'b0, 1'b1, 1'b0, byp[k]);
      chk($sformatf("byp_tdo_%0d", k), ifc.tdo, byp[k]);
    end
    qc.push_back(1'b1);
    drive_c(1'b0, 1'b0, 1'b1, 1'b0);
    chk("byp_updateData", ifc.updateData, 1);
    drive_c(1'b0, 1'b0, 1'b0, 1'b0);
    ifc.select = 1'b0;

    repeat (3) idle();
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
